freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 100_000_000: gate window length in clk_100MHz cycles (1 s at 100 MHz gives a reading in Hz); legal range 32..2^27-1.
REQ-002 SHALL have port clk_100MHz, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port sig_in, input, 1 bit: signal under measurement, asynchronous to clk_100MHz.
REQ-005 SHALL have port bcd, output, 16 bits: last reading as 4 packed BCD digits, thousands in [15:12].
REQ-006 SHALL have port over, output, 1 bit: last reading exceeded 9999 rising edges.
REQ-007 SHALL have port valid, output, 1 bit: one-cycle pulse when bcd/over update.

Function
REQ-008 SHALL pass sig_in through a 2-flop synchronizer and a third history flop, with rising edge = sync2 high and history low.
REQ-009 An edge SHALL be counted 3 cycles after sig_in rises (synchronizer plus detect latency); minimum detectable period is 2 clk cycles.
REQ-010 SHALL run a gate counter 0..GATE_CYCLES-1, wrapping continuously with no dead cycles between windows.
REQ-011 SHALL count detected edges in a 24-bit edge counter that saturates at 2^24-1 and never wraps.
REQ-012 On the cycle gate counter = GATE_CYCLES-1: the total SHALL include any edge detected that cycle; the total is latched for conversion; the edge counter restarts at 0 next cycle.
REQ-013 An edge detected on the first cycle of a new window SHALL count in the new window only.
REQ-014 If the latched total > 9999, conversion SHALL use 9999 and over SHALL become 1; otherwise over SHALL become 0.
REQ-015 Control FSM SHALL have states GATE (counting, converter idle), CONV (waiting for converter done), and PUBLISH (one cycle: update bcd/over, assert valid, return to GATE).
REQ-016 Gate and edge counting SHALL continue unaffected in CONV and PUBLISH.
REQ-017 The latch at REQ-012 SHALL trigger GATE->CONV in the same cycle it occurs.
REQ-018 Conversion SHALL be sequential shift-add-3 over 14 bits, taking exactly 15 cycles from start to done.
REQ-019 valid SHALL assert exactly 17 cycles after the latching cycle.
REQ-020 bcd/over SHALL hold their values between valid pulses.
REQ-021 GATE_CYCLES >= 32 SHALL guarantee conversion completes before the next window closes; no result is ever dropped.

Reset
REQ-022 While reset_n = 0 at a clock edge: gate counter = 0, edge counter = 0, FSM = GATE, bcd = 16'h0000, over = 0, valid = 0.
REQ-023 Synchronizer and history flops SHALL reset to 1, so sig_in held high through reset release counts no edge.
REQ-024 Reset asserted mid-window or mid-conversion SHALL abort it; no valid pulse SHALL be produced for the aborted window.
REQ-025 The first window SHALL begin on the first cycle with reset_n = 1.

Structure
REQ-026 A shared package SHALL hold: FSM state enum (GATE, CONV, PUBLISH), BCD_MAX = 9999, edge counter width 24, BCD width 16.
REQ-027 Sub-module bin2bcd_seq SHALL implement REQ-018 with ports clk_100MHz, reset_n, start, bin[13:0], done, bcd[15:0].
REQ-028 freq_meter SHALL hold the synchronizer, counters, saturation, and FSM.

Verification (GATE_CYCLES = 1000 unless stated)
REQ-029 sig_in square wave, period 10 cycles -> every window: bcd = 16'h0100, over = 0, valid 17 cycles after window end.
REQ-030 sig_in held 0; separately sig_in held 1 across reset release -> bcd = 16'h0000, over = 0 on each valid.
REQ-031 GATE_CYCLES = 25000, sig_in toggles every cycle (12500 edges) -> bcd = 16'h9999, over = 1.
REQ-032 Single edge timed to be detected on cycle 999 of a window, then one on cycle 0 of the next -> consecutive readings 16'h0001, 16'h0001.
REQ-033 reset_n low for 1 cycle at cycle 500 with a 10-cycle-period input -> no valid for the aborted window, bcd = 16'h0000 until the next full window reads 16'h0100.
REQ-034 Frequency change from period 10 to period 4 at a window boundary -> readings 16'h0100 then 16'h0250, with no missed valid pulse.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter and its BCD converter.
package freq_meter_pkg;
    typedef enum logic [1:0] {GATE, CONV, PUBLISH} state_t;

    localparam int BCD_MAX = 9999;
    localparam int EDGE_W  = 24;
    localparam int BCD_W   = 16;
    localparam int BIN_W   = 14;
endpackage

// File: rtl/freq_meter_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one shift per cycle over
// BIN_W bits, done asserted exactly 15 cycles after start.
module bin2bcd_seq
    import freq_meter_pkg::*;
(
    input  logic             clk_100MHz,
    input  logic             reset_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);
    localparam int SR_W = BCD_W + BIN_W;

    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] adj;
    logic [3:0]      cnt;

    always_comb begin
        adj = sr;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (sr[BIN_W + 4*i +: 4] >= 4'd5)
                adj[BIN_W + 4*i +: 4] = sr[BIN_W + 4*i +: 4] + 4'd3;
        end
    end

    // Load on start, then 14 shifts; done rises with the final shift.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            sr   <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr  <= {{BCD_W{1'b0}}, bin};
                cnt <= 4'(BIN_W);
            end else if (cnt != 4'd0) begin
                sr  <= {adj[SR_W-2:0], 1'b0};
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1)
                    done <= 1'b1;
            end
        end
    end

    assign bcd = sr[SR_W-1 -: BCD_W];
endmodule

// File: rtl/freq_meter.sv
// Gated rising-edge counter: counts sig_in edges per GATE_CYCLES window and
// publishes the clamped total as 4 BCD digits with an overflow flag.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 100_000_000
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic [BCD_W-1:0] bcd,
    output logic             over,
    output logic             valid
);
    localparam int                 GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [EDGE_W-1:0]  EDGE_SAT  = '1;

    logic              sync1, sync2, hist, rise;
    logic [GATE_W-1:0] gate_cnt;
    logic [EDGE_W-1:0] edge_cnt, edge_next;
    logic              window_end;
    logic              total_over;
    logic [BIN_W-1:0]  total_bin;
    logic [BIN_W-1:0]  conv_bin;
    logic              conv_over, conv_start, conv_done;
    logic [BCD_W-1:0]  conv_bcd;
    state_t            state, state_next;

    // Reset high so a signal already high at release is not seen as an edge.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            {sync1, sync2, hist} <= 3'b111;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise       = sync2 & ~hist;
    assign window_end = (gate_cnt == GATE_LAST);
    assign edge_next  = (rise && edge_cnt != EDGE_SAT) ? edge_cnt + EDGE_W'(1) : edge_cnt;
    assign total_over = (edge_next > EDGE_W'(BCD_MAX));
    assign total_bin  = total_over ? BIN_W'(BCD_MAX) : edge_next[BIN_W-1:0];

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else begin
            gate_cnt <= window_end ? '0 : gate_cnt + GATE_W'(1);
            edge_cnt <= window_end ? '0 : edge_next;
        end
    end

    // The closing window's total, including an edge on its last cycle.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            conv_bin   <= '0;
            conv_over  <= 1'b0;
            conv_start <= 1'b0;
        end else begin
            conv_start <= 1'b0;
            if (window_end && state == GATE) begin
                conv_bin   <= total_bin;
                conv_over  <= total_over;
                conv_start <= 1'b1;
            end
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .start      (conv_start),
        .bin        (conv_bin),
        .done       (conv_done),
        .bcd        (conv_bcd)
    );

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) state <= GATE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            GATE:    if (window_end) state_next = CONV;
            CONV:    if (conv_done)  state_next = PUBLISH;
            PUBLISH: state_next = GATE;
            default: state_next = GATE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            bcd  <= '0;
            over <= 1'b0;
        end else if (state == CONV && conv_done) begin
            bcd  <= conv_bcd;
            over <= conv_over;
        end
    end

    assign valid = (state == PUBLISH);
endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: readings expected per window are queued as
// stimulus is planned and popped when valid pulses.
module tb_freq_meter;
    typedef struct {
        logic [15:0] bcd;
        logic        over;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_in = 1'b0;
    logic [15:0] bcd;
    logic        over, valid;
    logic        rst2_n = 1'b0;
    logic        sig2 = 1'b0;
    logic [15:0] bcd2;
    logic        over2, valid2;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    // Reference window position for the 1000-cycle instance.
    int          abs_cyc = 0;
    logic [16:0] vhist = '0;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(1000)) dut (
        .clk_100MHz (clk),
        .reset_n    (rst_n),
        .sig_in     (sig_in),
        .bcd        (bcd),
        .over       (over),
        .valid      (valid)
    );

    freq_meter #(.GATE_CYCLES(25000)) dut2 (
        .clk_100MHz (clk),
        .reset_n    (rst2_n),
        .sig_in     (sig2),
        .bcd        (bcd2),
        .over       (over2),
        .valid      (valid2)
    );

    always @(posedge clk) begin
        if (!rst_n) begin
            abs_cyc <= 0;
            vhist   <= '0;
        end else begin
            abs_cyc <= abs_cyc + 1;
            vhist   <= {vhist[15:0], (abs_cyc % 1000) == 999};
        end
    end

    function automatic logic wave(int mode, int a);
        case (mode)
            1:       return 1'b1;
            10:      return ((a / 5) % 2) == 1;
            2:       return (a < 997) ? ((a / 5) % 2) == 1 : ((a / 2) % 2) == 1;
            3:       return (a >= 997 && a < 1500) || a >= 1998;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t mk(logic [15:0] b, logic o);
        exp_t e;
        e.bcd  = b;
        e.over = o;
        return e;
    endfunction

    task automatic run_until(int mode, int end_abs);
        while (abs_cyc < end_abs) begin
            sig_in = wave(mode, abs_cyc);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1 || vhist[16]) begin
                checks++;
                if (valid !== vhist[16]) begin
                    errors++;
                    $display("FAIL valid_timing abs=%0d got %b want %b", abs_cyc, valid, vhist[16]);
                end
            end
            if (valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_reading got bcd=%h over=%b want none", bcd, over);
                end else begin
                    e = sb.pop_front();
                    if (bcd !== e.bcd || over !== e.over) begin
                        errors++;
                        $display("FAIL reading got bcd=%h over=%b want bcd=%h over=%b",
                                 bcd, over, e.bcd, e.over);
                    end
                end
            end
        end
    endtask

    task automatic check_drained(string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_valid got %0d pending want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rst2_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd got %h want 0000", bcd); end
        if (over !== 1'b0)    begin errors++; $display("FAIL reset_over got %b want 0", over); end
        if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        if (valid2 !== 1'b0 || bcd2 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_dut2 got valid=%b bcd=%h want 0/0000", valid2, bcd2);
        end
    endtask

    task automatic test_period10();
        do_reset();
        repeat (3) sb.push_back(mk(16'h0100, 1'b0));
        run_until(10, 3020);
        check_drained("period10");
    endtask

    task automatic test_const();
        sig_in = 1'b0;
        do_reset();
        repeat (2) sb.push_back(mk(16'h0000, 1'b0));
        run_until(0, 2020);
        check_drained("const_low");
        sig_in = 1'b1;
        do_reset();
        repeat (2) sb.push_back(mk(16'h0000, 1'b0));
        run_until(1, 2020);
        check_drained("const_high");
    endtask

    // Edges detected on cycle 999 of window 0 and cycle 0 of window 2.
    task automatic test_boundary();
        sig_in = 1'b0;
        do_reset();
        sb.push_back(mk(16'h0001, 1'b0));
        sb.push_back(mk(16'h0000, 1'b0));
        sb.push_back(mk(16'h0001, 1'b0));
        run_until(3, 3020);
        check_drained("boundary");
    endtask

    task automatic test_freq_change();
        sig_in = 1'b0;
        do_reset();
        sb.push_back(mk(16'h0100, 1'b0));
        sb.push_back(mk(16'h0250, 1'b0));
        sb.push_back(mk(16'h0250, 1'b0));
        run_until(2, 3020);
        check_drained("freq_change");
    endtask

    task automatic test_abort();
        checks++;
        if (bcd !== 16'h0250) begin errors++; $display("FAIL hold_before_abort got %h want 0250", bcd); end
        run_until(10, 3500);
        rst_n = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bcd !== 16'h0000) begin errors++; $display("FAIL abort_bcd got %h want 0000", bcd); end
        if (over !== 1'b0)    begin errors++; $display("FAIL abort_over got %b want 0", over); end
        rst_n = 1'b1;
        run_until(10, 1015);
        checks++;
        if (bcd !== 16'h0000) begin errors++; $display("FAIL abort_hold got %h want 0000", bcd); end
        sb.push_back(mk(16'h0100, 1'b0));
        run_until(10, 1020);
        check_drained("abort");
    endtask

    task automatic test_over();
        int seen = -1;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        sig2 = 1'b0;
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 0; k < 25100 && seen < 0; k++) begin
            sig2 = k[0];
            if (valid2 === 1'b1) seen = k;
            else @(negedge clk);
        end
        checks += 3;
        if (seen != 25016) begin
            errors++;
            $display("FAIL over_valid_cycle got %0d want 25016", seen);
        end
        if (bcd2 !== 16'h9999) begin errors++; $display("FAIL over_bcd got %h want 9999", bcd2); end
        if (over2 !== 1'b1)    begin errors++; $display("FAIL over_flag got %b want 1", over2); end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_period10();
        test_const();
        test_boundary();
        test_freq_change();
        test_abort();
        test_over();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
